piso_arb_ctrl: RTL and testbench

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

---
 rtl/piso_arb_ctrl.sv | 136 +++++++++++++
 tb/tb_piso_arb_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin nibble arbiter feeding an LSB-first serializer.
// Optional even-parity fifth bit is enabled by defining PISO_ARB_PARITY_EN.
module piso_arb_ctrl #(
   parameter int IDLE_GAP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [3:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_data,
   output logic       req1_ready,
   output logic       ser_out,
   output logic       ser_valid,
   output logic       ser_last,
   output logic       grant_id,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

`ifdef PISO_ARB_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

   state_t     state, state_nxt;
   logic [3:0] q;
   logic [1:0] bit_cnt;
   logic [3:0] gap_cnt;
   logic       last_grant;
   logic       pick;
   logic [3:0] sel_data;
   logic       load;
   logic       frame_done;
`ifdef PISO_ARB_PARITY_EN
   logic       par_bit;
`endif

   // Tie goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      pick     = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
      sel_data = pick ? req1_data : req0_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      ser_out    = 1'b0;
      ser_valid  = 1'b0;
      ser_last   = 1'b0;
      busy       = (state != IDLE);
      load       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            // Gating by reset keeps both readies low while reset is held.
            if (reset && (req0_valid || req1_valid)) begin
               req0_ready = ~pick;
               req1_ready = pick;
               load       = 1'b1;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = q[0];
            if (bit_cnt == 2'd3) begin
`ifdef PISO_ARB_PARITY_EN
               state_nxt = PAR;
`else
               ser_last   = 1'b1;
               frame_done = 1'b1;
               state_nxt  = (IDLE_GAP == 0) ? IDLE : GAP;
`endif
            end
         end
`ifdef PISO_ARB_PARITY_EN
         PAR: begin
            ser_valid  = 1'b1;
            ser_out    = par_bit;
            ser_last   = 1'b1;
            frame_done = 1'b1;
            state_nxt  = (IDLE_GAP == 0) ? IDLE : GAP;
         end
`endif
         GAP: begin
            if (gap_cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q          <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         frame_cnt  <= '0;
`ifdef PISO_ARB_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         if (load) begin
            q          <= sel_data;
            bit_cnt    <= '0;
            grant_id   <= pick;
            last_grant <= pick;
`ifdef PISO_ARB_PARITY_EN
            par_bit    <= ^sel_data;
`endif
         end else if (state == SHIFT) begin
            q       <= {1'b0, q[3:1]};
            bit_cnt <= bit_cnt + 2'd1;
         end
         if (frame_done) begin
            frame_cnt <= frame_cnt + 8'd1;
            gap_cnt   <= GAP_LOAD;
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: three instances (IDLE_GAP 1, 0, 3) against a frame-position model.
module tb_piso_arb_ctrl;

`ifdef PISO_ARB_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       v    [3][2];
   logic [3:0] d    [3][2];
   logic       rdy0 [3];
   logic       rdy1 [3];
   logic       so   [3];
   logic       sv   [3];
   logic       sl   [3];
   logic       gid  [3];
   logic       bsy  [3];
   logic [7:0] fc   [3];

   int checks   = 0;
   int failures = 0;
   int mode     = 0;

   function automatic int gap_of(int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      piso_arb_ctrl #(.IDLE_GAP((g == 0) ? 1 : ((g == 1) ? 0 : 3))) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req0_valid (v[g][0]),
         .req0_data  (d[g][0]),
         .req0_ready (rdy0[g]),
         .req1_valid (v[g][1]),
         .req1_data  (d[g][1]),
         .req1_ready (rdy1[g]),
         .ser_out    (so[g]),
         .ser_valid  (sv[g]),
         .ser_last   (sl[g]),
         .grant_id   (gid[g]),
         .busy       (bsy[g]),
         .frame_cnt  (fc[g])
      );
   end

   // Model: pos = cycles since handshake (0 = idle); bits at 1..FL, gap after.
   int         pos   [3];
   logic [3:0] mdata [3];
   logic       mgid  [3];
   logic       mlast [3];
   logic [7:0] mfc   [3];
   logic       hs    [3][2];

   function automatic logic winner(int k);
      if (v[k][0] && v[k][1]) return !mlast[k];
      return !v[k][0];
   endfunction

   function automatic logic exp_rdy(int k, int r);
      return reset && pos[k] == 0 && v[k][r] && (int'(winner(k)) == r);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            pos[k]   <= 0;
            mdata[k] <= '0;
            mgid[k]  <= 1'b0;
            mlast[k] <= 1'b1;
            mfc[k]   <= '0;
            hs[k][0] <= 1'b0;
            hs[k][1] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            hs[k][0] <= exp_rdy(k, 0);
            hs[k][1] <= exp_rdy(k, 1);
            if (pos[k] == 0) begin
               if (exp_rdy(k, 0) || exp_rdy(k, 1)) begin
                  pos[k]   <= 1;
                  mdata[k] <= d[k][winner(k)];
                  mgid[k]  <= winner(k);
                  mlast[k] <= winner(k);
               end
            end else begin
               if (pos[k] == FL) mfc[k] <= mfc[k] + 8'd1;
               if (pos[k] == FL + gap_of(k)) pos[k] <= 0;
               else                          pos[k] <= pos[k] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int          p;
         logic        e_sv, e_so;
         logic [14:0] e, a;
         p    = pos[k];
         e_sv = (p >= 1 && p <= FL);
         e_so = 1'b0;
         if (e_sv) e_so = (p <= 4) ? mdata[k][p-1] : ^mdata[k];
         e = {exp_rdy(k, 0), exp_rdy(k, 1), e_so, e_sv, (p == FL), mgid[k], (p != 0), mfc[k]};
         a = {rdy0[k], rdy1[k], so[k], sv[k], sl[k], gid[k], bsy[k], fc[k]};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL model_cmp dut%0d t=%0t actual=%b required=%b", k, $time, a, e);
         end
      end
   end

   // Requesters hold valid/data until accepted; random mode occasionally withdraws.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         case (mode)
            0: begin v[k][0] = 1'b0; v[k][1] = 1'b0; end
            1: begin v[k][0] = 1'b1; d[k][0] = 4'b1011; v[k][1] = 1'b0; end
            2: begin v[k][0] = 1'b1; d[k][0] = 4'hA; v[k][1] = 1'b1; d[k][1] = 4'h5; end
            default: begin
               for (int r = 0; r < 2; r++) begin
                  if (v[k][r] && !hs[k][r]) begin
                     if ($urandom_range(19) == 0) v[k][r] = 1'b0;
                  end else begin
                     v[k][r] = ($urandom_range(2) != 0);
                     d[k][r] = 4'($urandom);
                  end
               end
            end
         endcase
      end
   end

   task automatic lit(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic wait_ready(input int k, output int who);
      who = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy0[k]) begin who = 0; return; end
         if (rdy1[k]) begin who = 1; return; end
      end
      checks++;
      failures++;
      $display("FAIL wait_ready dut%0d actual=timeout required=ready", k);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      int         who;
      int         cnt;
      logic [3:0] pat;
      pat = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         v[k][0] = 1'b0; v[k][1] = 1'b0; d[k][0] = '0; d[k][1] = '0;
      end
      reset = 1'b1;
      #1 reset = 1'b0;
      mode = 2;
      repeat (3) @(negedge clk);
      lit("rst_ready0", rdy0[0], 0);
      lit("rst_ready1", rdy1[0], 0);
      lit("rst_busy", bsy[0], 0);
      lit("rst_frame_cnt", fc[0], 0);
      lit("rst_grant_id", gid[0], 0);
      lit("rst_ser_valid", sv[0], 0);

      // Tie from reset: requester 0 first, then strict alternation.
      @(posedge clk); #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready(0, who);
         lit("tie_order", who, i % 2);
         @(negedge clk);
         lit("tie_grant_id", gid[0], i % 2);
      end

      // Single frame 4'b1011 on the IDLE_GAP=1 instance.
      mode = 1;
      pulse_reset();
      wait_ready(0, who);
      lit("single_winner", who, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         lit("single_bit", so[0], int'(pat[i]));
         lit("single_valid", sv[0], 1);
         lit("single_last", sl[0], (i == 3 && FL == 4) ? 1 : 0);
      end
      if (FL == 5) begin
         @(negedge clk);
         lit("parity_bit", so[0], 1);
         lit("parity_last", sl[0], 1);
      end
      @(negedge clk);
      lit("single_frame_cnt", fc[0], 1);
      lit("single_gap_ready", rdy0[0], 0);
      @(negedge clk);
      lit("single_ready_again", rdy0[0], 1);

      // Reset during the second bit aborts the frame immediately.
      wait_ready(0, who);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      lit("abort_ser_valid", sv[0], 0);
      lit("abort_ser_out", so[0], 0);
      lit("abort_busy", bsy[0], 0);
      lit("abort_frame_cnt", fc[0], 0);
      lit("abort_ready", rdy0[0], 0);
      @(posedge clk); #1 reset = 1'b1;
      wait_ready(0, who);
      lit("abort_next_winner", who, 0);

      // 256 frames on the IDLE_GAP=0 instance: wrap and back-to-back handshake.
      pulse_reset();
      cnt = 0;
      for (int i = 0; i < 300 * (FL + 1) && cnt < 256; i++) begin
         @(negedge clk);
         if (sl[1]) begin
            cnt++;
            if (cnt == 256) lit("wrap_pre", fc[1], 255);
         end
      end
      if (cnt < 256) begin
         lit("wrap_timeout", cnt, 256);
      end else begin
         @(negedge clk);
         lit("wrap_frame_cnt", fc[1], 0);
         lit("b2b_ready", rdy0[1], 1);
      end

      mode = 3;
      repeat (3000) @(negedge clk);
      mode = 0;
      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
